trap_ctrl: RTL and testbench

Machine-mode trap sequencer sitting between the core pipeline and the CSR file. At each instruction boundary it arbitrates pending interrupts and synchronous exceptions, or accepts an `mret`. It then drives a flush/commit/redirect sequence. The CSR file latches `mepc`/`mcause`/`mtval` and the `mstatus` stack from this block's one-cycle commit strobes.

---
 rtl/trap_pkg.sv | 37 +++
 rtl/trap_prio.sv | 64 ++++++
 rtl/trap_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_trap_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
package trap_pkg;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_COMMIT,
        ST_MRET,
        ST_REDIRECT
    } state_e;

    // Exception cause codes.
    localparam logic [3:0] CAUSE_IALIGN  = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0] CAUSE_BREAK   = 4'd3;
    localparam logic [3:0] CAUSE_ECALL   = 4'd11;

    // Interrupt cause codes.
    localparam logic [3:0] CAUSE_MSI     = 4'd3;
    localparam logic [3:0] CAUSE_MTI     = 4'd7;
    localparam logic [3:0] CAUSE_MEI     = 4'd11;

    // mip/mie bit positions.
    localparam int MIP_MSI_BIT = 3;
    localparam int MIP_MTI_BIT = 7;
    localparam int MIP_MEI_BIT = 11;

    // mtvec.MODE encoding that enables vectored interrupts.
    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;

    // Only misaligned-fetch and illegal-instruction traps carry a faulting value.
    function automatic logic cause_has_tval(input logic [3:0] code);
        return (code == CAUSE_IALIGN) || (code == CAUSE_ILLEGAL);
    endfunction

endpackage

// File: rtl/trap_prio.sv
// Combinational priority encoder: picks the winning event at an instruction
// boundary (interrupt > exception > mret) and its 4-bit cause code.
module trap_prio
    import trap_pkg::*;
(
    input  logic       i_exc_ialign,
    input  logic       i_exc_illegal,
    input  logic       i_exc_break,
    input  logic       i_exc_ecall,
    input  logic       i_is_mret,
    input  logic       i_irq_msi,
    input  logic       i_irq_mti,
    input  logic       i_irq_mei,
    input  logic       i_mie_msie,
    input  logic       i_mie_mtie,
    input  logic       i_mie_meie,
    input  logic       i_mstatus_mie,
    output logic       o_evt_vld,
    output logic       o_is_int,
    output logic       o_is_mret,
    output logic [3:0] o_code
);

    logic w_pend_msi;
    logic w_pend_mti;
    logic w_pend_mei;

    // An interrupt is taken only when raised, individually enabled and globally enabled.
    assign w_pend_msi = i_mstatus_mie & i_irq_msi & i_mie_msie;
    assign w_pend_mti = i_mstatus_mie & i_irq_mti & i_mie_mtie;
    assign w_pend_mei = i_mstatus_mie & i_irq_mei & i_mie_meie;

    // Fixed-priority selection: MEI > MSI > MTI > ialign > illegal > break > ecall > mret.
    always_comb begin
        // NOTE: every output gets a default before the if-chain so no path leaves one unassigned (no latch).
        o_evt_vld = 1'b1;
        o_is_int  = 1'b0;
        o_is_mret = 1'b0;
        o_code    = CAUSE_IALIGN;
        if (w_pend_mei) begin
            o_is_int = 1'b1;
            o_code   = CAUSE_MEI;
        end else if (w_pend_msi) begin
            o_is_int = 1'b1;
            o_code   = CAUSE_MSI;
        end else if (w_pend_mti) begin
            o_is_int = 1'b1;
            o_code   = CAUSE_MTI;
        end else if (i_exc_ialign) begin
            o_code   = CAUSE_IALIGN;
        end else if (i_exc_illegal) begin
            o_code   = CAUSE_ILLEGAL;
        end else if (i_exc_break) begin
            o_code   = CAUSE_BREAK;
        end else if (i_exc_ecall) begin
            o_code   = CAUSE_ECALL;
        end else if (i_is_mret) begin
            o_is_mret = 1'b1;
        end else begin
            o_evt_vld = 1'b0;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer. At an instruction boundary it latches the winning
// event, then runs flush -> commit strobe -> redirect handshake.
// Build option: define TRAP_CTRL_VECTOR_EN to offset interrupt targets by
// 4*cause when mtvec is in vectored mode; otherwise every trap goes to the base.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int XLEN = 32
)(
    input  logic            clk,
    input  logic            rstl,
    input  logic            instr_vld,
    input  logic [XLEN-1:0] pc_now,
    input  logic            exc_ialign,
    input  logic            exc_illegal,
    input  logic            exc_break,
    input  logic            exc_ecall,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            is_mret,
    input  logic            irq_msi,
    input  logic            irq_mti,
    input  logic            irq_mei,
    input  logic            mie_msie,
    input  logic            mie_mtie,
    input  logic            mie_meie,
    input  logic            mstatus_mie,
    input  logic [XLEN-3:0] mtvec_base,
    input  logic [1:0]      mtvec_mode,
    input  logic [XLEN-1:0] mepc,
    output logic            busy,
    output logic            flush,
    input  logic            flush_ack,
    output logic            trap_commit,
    output logic            mret_commit,
    output logic            cause_int,
    output logic [3:0]      cause_code,
    output logic [XLEN-1:0] epc,
    output logic [XLEN-1:0] tval,
    output logic            redirect_vld,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_rdy
);

    state_e          r_state;
    state_e          w_state_nxt;

    logic            w_evt_vld;
    logic            w_evt_int;
    logic            w_evt_mret;
    logic [3:0]      w_evt_code;
    logic            w_take_evt;
    logic [XLEN-1:0] w_trap_pc;

    logic            r_busy;
    logic            r_flush;
    logic            r_trap_commit;
    logic            r_mret_commit;
    logic            r_redirect_vld;
    logic            r_is_mret;
    logic            r_cause_int;
    logic [3:0]      r_cause_code;
    logic [XLEN-1:0] r_epc;
    logic [XLEN-1:0] r_tval;
    logic [XLEN-1:0] r_redirect_pc;

    trap_prio u_prio (
        .i_exc_ialign  (exc_ialign),
        .i_exc_illegal (exc_illegal),
        .i_exc_break   (exc_break),
        .i_exc_ecall   (exc_ecall),
        .i_is_mret     (is_mret),
        .i_irq_msi     (irq_msi),
        .i_irq_mti     (irq_mti),
        .i_irq_mei     (irq_mei),
        .i_mie_msie    (mie_msie),
        .i_mie_mtie    (mie_mtie),
        .i_mie_meie    (mie_meie),
        .i_mstatus_mie (mstatus_mie),
        .o_evt_vld     (w_evt_vld),
        .o_is_int      (w_evt_int),
        .o_is_mret     (w_evt_mret),
        .o_code        (w_evt_code)
    );

    // Boundaries are only sampled while idle; anything else is ignored.
    assign w_take_evt = (r_state == ST_IDLE) && instr_vld && w_evt_vld;

`ifdef TRAP_CTRL_VECTOR_EN
    // Trap target: interrupts in vectored mode land at base + 4*cause, wrapping in XLEN bits.
    always_comb begin
        w_trap_pc = {mtvec_base, 2'b00};
        if ((mtvec_mode == MTVEC_MODE_VECTORED) && r_cause_int) begin
            w_trap_pc = {mtvec_base, 2'b00} + (XLEN'(r_cause_code) << 2);
        end
    end
`else
    logic w_unused_mode;

    // Trap target: always the base; the mode field has no effect in this build.
    assign w_trap_pc     = {mtvec_base, 2'b00};
    assign w_unused_mode = ^mtvec_mode;
`endif

    // Next-state logic for the flush/commit/redirect sequence.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:     if (w_take_evt)   w_state_nxt = ST_FLUSH;
            ST_FLUSH:    if (flush_ack)    w_state_nxt = r_is_mret ? ST_MRET : ST_COMMIT;
            ST_COMMIT:                     w_state_nxt = ST_REDIRECT;
            ST_MRET:                       w_state_nxt = ST_REDIRECT;
            ST_REDIRECT: if (redirect_rdy) w_state_nxt = ST_IDLE;
            default:                       w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstl) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rstl) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Control outputs registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rstl) begin
        if (!rstl) begin
            r_busy         <= 1'b0;
            r_flush        <= 1'b0;
            r_trap_commit  <= 1'b0;
            r_mret_commit  <= 1'b0;
            r_redirect_vld <= 1'b0;
        end else begin
            r_busy         <= (w_state_nxt != ST_IDLE);
            r_flush        <= (w_state_nxt == ST_FLUSH);
            r_trap_commit  <= (w_state_nxt == ST_COMMIT);
            r_mret_commit  <= (w_state_nxt == ST_MRET);
            r_redirect_vld <= (w_state_nxt == ST_REDIRECT);
        end
    end

    // Capture the event at the boundary; held until the next accepted event.
    always_ff @(posedge clk or negedge rstl) begin
        if (!rstl) begin
            r_is_mret    <= 1'b0;
            r_cause_int  <= 1'b0;
            r_cause_code <= '0;
            r_epc        <= '0;
            r_tval       <= '0;
        end else if (w_take_evt) begin
            r_is_mret    <= w_evt_mret;
            r_cause_int  <= w_evt_int;
            r_cause_code <= w_evt_code;
            r_epc        <= pc_now;
            r_tval       <= (!w_evt_int && !w_evt_mret && cause_has_tval(w_evt_code)) ? exc_tval : '0;
        end
    end

    // Redirect target is fixed on entry to REDIRECT and held through the handshake.
    always_ff @(posedge clk or negedge rstl) begin
        if (!rstl) begin
            r_redirect_pc <= '0;
        end else if (r_state == ST_COMMIT) begin
            r_redirect_pc <= w_trap_pc;
        end else if (r_state == ST_MRET) begin
            r_redirect_pc <= mepc;
        end
    end

    assign busy         = r_busy;
    assign flush        = r_flush;
    assign trap_commit  = r_trap_commit;
    assign mret_commit  = r_mret_commit;
    assign redirect_vld = r_redirect_vld;
    assign redirect_pc  = r_redirect_pc;
    assign cause_int    = r_cause_int;
    assign cause_code   = r_cause_code;
    assign epc          = r_epc;
    assign tval         = r_tval;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed vector table plus randomized
// boundaries checked against a behavioural model of the trap rules.
`timescale 1ns/1ps
module tb_trap_ctrl;
    import trap_pkg::*;

    localparam int XLEN = 32;
`ifdef TRAP_CTRL_VECTOR_EN
    localparam bit VEC = 1'b1;
`else
    localparam bit VEC = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rstl = 1'b0;
    logic            instr_vld, exc_ialign, exc_illegal, exc_break, exc_ecall, is_mret;
    logic            irq_msi, irq_mti, irq_mei, mie_msie, mie_mtie, mie_meie, mstatus_mie;
    logic [XLEN-1:0] pc_now, exc_tval, mepc;
    logic [XLEN-3:0] mtvec_base;
    logic [1:0]      mtvec_mode;
    logic            flush_ack, redirect_rdy;
    logic            busy, flush, trap_commit, mret_commit, cause_int, redirect_vld;
    logic [3:0]      cause_code;
    logic [XLEN-1:0] epc, tval, redirect_pc;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    trap_ctrl #(.XLEN(XLEN)) dut (
        .clk(clk), .rstl(rstl), .instr_vld(instr_vld), .pc_now(pc_now),
        .exc_ialign(exc_ialign), .exc_illegal(exc_illegal), .exc_break(exc_break),
        .exc_ecall(exc_ecall), .exc_tval(exc_tval), .is_mret(is_mret),
        .irq_msi(irq_msi), .irq_mti(irq_mti), .irq_mei(irq_mei),
        .mie_msie(mie_msie), .mie_mtie(mie_mtie), .mie_meie(mie_meie),
        .mstatus_mie(mstatus_mie), .mtvec_base(mtvec_base), .mtvec_mode(mtvec_mode),
        .mepc(mepc), .busy(busy), .flush(flush), .flush_ack(flush_ack),
        .trap_commit(trap_commit), .mret_commit(mret_commit), .cause_int(cause_int),
        .cause_code(cause_code), .epc(epc), .tval(tval), .redirect_vld(redirect_vld),
        .redirect_pc(redirect_pc), .redirect_rdy(redirect_rdy)
    );

    // Boundary stimulus. exc = {ecall, break, illegal, ialign}, irq = {mei, mti, msi},
    // mie = {meie, mtie, msie}; base is the full byte address of the vector table.
    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  exc;
        logic [31:0] tval;
        logic        mret;
        logic [2:0]  irq;
        logic [2:0]  mie;
        logic        smie;
        logic [31:0] base;
        logic [1:0]  mode;
        logic [31:0] mepc;
    } vec_t;

    typedef struct packed {
        logic        evt;
        logic        mret;
        logic        cint;
        logic [3:0]  code;
        logic [31:0] tval;
        logic [31:0] rpc;
    } exp_t;

    typedef struct packed {
        vec_t       v;
        exp_t       e;
        logic [2:0] ack_dly;
        logic [2:0] rdy_dly;
    } tv_t;

    tv_t tbl [14];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference model: interrupts and exceptions are indexed by their cause number,
    // then walked in the architectural priority order.
    function automatic exp_t model(input vec_t v);
        exp_t        e;
        logic [11:0] mip, mie, pend;
        logic [15:0] raised;
        int          irq_rank [3];
        int          exc_rank [4];
        irq_rank = '{11, 3, 7};
        exc_rank = '{0, 2, 3, 11};
        e = '0;
        mip = '0;
        mie = '0;
        mip[MIP_MSI_BIT] = v.irq[0];
        mip[MIP_MTI_BIT] = v.irq[1];
        mip[MIP_MEI_BIT] = v.irq[2];
        mie[MIP_MSI_BIT] = v.mie[0];
        mie[MIP_MTI_BIT] = v.mie[1];
        mie[MIP_MEI_BIT] = v.mie[2];
        pend = v.smie ? (mip & mie) : 12'h0;
        raised = '0;
        raised[0]  = v.exc[0];
        raised[2]  = v.exc[1];
        raised[3]  = v.exc[2];
        raised[11] = v.exc[3];
        foreach (irq_rank[i]) begin
            if (!e.evt && pend[irq_rank[i]]) begin
                e.evt  = 1'b1;
                e.cint = 1'b1;
                e.code = 4'(irq_rank[i]);
            end
        end
        foreach (exc_rank[i]) begin
            if (!e.evt && raised[exc_rank[i]]) begin
                e.evt  = 1'b1;
                e.code = 4'(exc_rank[i]);
                if (exc_rank[i] == 0 || exc_rank[i] == 2) e.tval = v.tval;
            end
        end
        if (!e.evt && v.mret) begin
            e.evt  = 1'b1;
            e.mret = 1'b1;
            e.rpc  = v.mepc;
        end
        if (e.evt && !e.mret) begin
            e.rpc = v.base;
            if (VEC && e.cint && v.mode == 2'd1) e.rpc = v.base + 32'(e.code) * 32'd4;
        end
        return e;
    endfunction

    task automatic drive_idle();
        instr_vld = 1'b0; pc_now = '0; exc_tval = '0;
        exc_ialign = 1'b0; exc_illegal = 1'b0; exc_break = 1'b0; exc_ecall = 1'b0;
        is_mret = 1'b0; irq_msi = 1'b0; irq_mti = 1'b0; irq_mei = 1'b0;
    endtask

    task automatic drive_boundary(input vec_t v);
        instr_vld   = 1'b1;
        pc_now      = v.pc;
        exc_ialign  = v.exc[0];
        exc_illegal = v.exc[1];
        exc_break   = v.exc[2];
        exc_ecall   = v.exc[3];
        exc_tval    = v.tval;
        is_mret     = v.mret;
        irq_msi     = v.irq[0];
        irq_mti     = v.irq[1];
        irq_mei     = v.irq[2];
        mie_msie    = v.mie[0];
        mie_mtie    = v.mie[1];
        mie_meie    = v.mie[2];
        mstatus_mie = v.smie;
        mtvec_base  = v.base[31:2];
        mtvec_mode  = v.mode;
        mepc        = v.mepc;
    endtask

    // While busy: interrupts drop, and a fresh ecall boundary is offered that must be ignored.
    task automatic drive_noise();
        instr_vld = 1'b1; pc_now = $urandom; exc_tval = $urandom;
        exc_ialign = 1'b0; exc_illegal = 1'b0; exc_break = 1'b0; exc_ecall = 1'b1;
        is_mret = 1'b0; irq_msi = 1'b0; irq_mti = 1'b0; irq_mei = 1'b0;
    endtask

    // One full transaction; entered and left on a falling edge with the DUT idle.
    task automatic run_txn(input vec_t v, input exp_t e, input int ack_dly, input int rdy_dly, input string nm);
        int lat;
        flush_ack = 1'b0;
        redirect_rdy = 1'b0;
        drive_boundary(v);
        @(negedge clk);
        if (!e.evt) begin
            check({nm, " noevt_busy"}, busy, 0);
            check({nm, " noevt_flush"}, flush, 0);
            drive_idle();
            flush_ack = 1'b1;
            @(negedge clk);
            flush_ack = 1'b0;
            check({nm, " idle_ack_busy"}, busy, 0);
            check({nm, " idle_ack_strobe"}, {trap_commit, mret_commit}, 0);
            return;
        end
        lat = 1;
        check({nm, " busy"}, busy, 1);
        check({nm, " flush"}, flush, 1);
        drive_noise();
        for (int i = 0; i < ack_dly; i++) begin
            @(negedge clk);
            lat++;
            check({nm, " flush_hold"}, {flush, trap_commit, mret_commit}, 3'b100);
        end
        flush_ack = 1'b1;
        @(negedge clk);
        lat++;
        flush_ack = 1'b0;
        check({nm, " flush_drop"}, flush, 0);
        check({nm, " trap_commit"}, trap_commit, !e.mret);
        check({nm, " mret_commit"}, mret_commit, e.mret);
        check({nm, " epc"}, epc, v.pc);
        if (!e.mret) begin
            check({nm, " cause_int"}, cause_int, e.cint);
            check({nm, " cause_code"}, cause_code, e.code);
            check({nm, " tval"}, tval, e.tval);
        end
        @(negedge clk);
        lat++;
        check({nm, " redirect_vld"}, redirect_vld, 1);
        check({nm, " latency"}, lat, 3 + ack_dly);
        check({nm, " redirect_pc"}, redirect_pc, e.rpc);
        check({nm, " strobe_single"}, {trap_commit, mret_commit}, 0);
        for (int i = 0; i < rdy_dly; i++) begin
            @(negedge clk);
            check({nm, " vld_stable"}, redirect_vld, 1);
            check({nm, " pc_stable"}, redirect_pc, e.rpc);
        end
        redirect_rdy = 1'b1;
        @(negedge clk);
        redirect_rdy = 1'b0;
        drive_idle();
        check({nm, " back_idle"}, {busy, redirect_vld}, 0);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, " ctl"}, {busy, flush, trap_commit, mret_commit, redirect_vld, cause_int}, 0);
        check({nm, " code"}, cause_code, 0);
        check({nm, " epc"}, epc, 0);
        check({nm, " tval"}, tval, 0);
        check({nm, " rpc"}, redirect_pc, 0);
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        v.pc   = $urandom;
        v.exc  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
        v.tval = $urandom;
        v.mret = ($urandom_range(0, 3) == 0);
        v.irq  = 3'($urandom);
        v.mie  = 3'($urandom);
        v.smie = 1'($urandom_range(0, 1));
        v.base = $urandom & 32'hFFFF_FFFC;
        v.mode = 2'($urandom_range(0, 3));
        v.mepc = $urandom;
        return v;
    endfunction

    initial begin
        vec_t v;
        exp_t e;

        //                pc            exc      tval           mret  irq     mie     smie  base           mode  mepc
        tbl[0]  = tv_t'{vec_t'{32'h100, 4'b1000, 32'h0,         1'b0, 3'b000, 3'b111, 1'b1, 32'h800,       2'd0, 32'h0},
                        exp_t'{1'b1, 1'b0, 1'b0, 4'd11, 32'h0,    32'h800},                            3'd0, 3'd0};
        tbl[1]  = tv_t'{vec_t'{32'h200, 4'b0010, 32'h55,        1'b0, 3'b110, 3'b111, 1'b1, 32'h1000,      2'd1, 32'h0},
                        exp_t'{1'b1, 1'b0, 1'b1, 4'd11, 32'h0,    VEC ? 32'h102C : 32'h1000},          3'd1, 3'd0};
        tbl[2]  = tv_t'{vec_t'{32'h300, 4'b0010, 32'hDEAD,      1'b0, 3'b111, 3'b111, 1'b0, 32'h800,       2'd0, 32'h0},
                        exp_t'{1'b1, 1'b0, 1'b0, 4'd2,  32'hDEAD, 32'h800},                            3'd2, 3'd1};
        tbl[3]  = tv_t'{vec_t'{32'h400, 4'b0000, 32'h0,         1'b1, 3'b000, 3'b000, 1'b0, 32'h800,       2'd0, 32'h2004},
                        exp_t'{1'b1, 1'b1, 1'b0, 4'd0,  32'h0,    32'h2004},                           3'd0, 3'd4};
        tbl[4]  = tv_t'{vec_t'{32'h500, 4'b1001, 32'h1234,      1'b0, 3'b000, 3'b000, 1'b0, 32'h800,       2'd0, 32'h0},
                        exp_t'{1'b1, 1'b0, 1'b0, 4'd0,  32'h1234, 32'h800},                            3'd0, 3'd0};
        tbl[5]  = tv_t'{vec_t'{32'h600, 4'b1100, 32'h77,        1'b0, 3'b000, 3'b000, 1'b0, 32'h800,       2'd0, 32'h0},
                        exp_t'{1'b1, 1'b0, 1'b0, 4'd3,  32'h0,    32'h800},                            3'd1, 3'd1};
        tbl[6]  = tv_t'{vec_t'{32'h700, 4'b0000, 32'h0,         1'b0, 3'b011, 3'b111, 1'b1, 32'h400,       2'd1, 32'h0},
                        exp_t'{1'b1, 1'b0, 1'b1, 4'd3,  32'h0,    VEC ? 32'h40C : 32'h400},            3'd0, 3'd0};
        tbl[7]  = tv_t'{vec_t'{32'h800, 4'b0000, 32'h0,         1'b0, 3'b010, 3'b111, 1'b1, 32'h400,       2'd1, 32'h0},
                        exp_t'{1'b1, 1'b0, 1'b1, 4'd7,  32'h0,    VEC ? 32'h41C : 32'h400},            3'd0, 3'd2};
        tbl[8]  = tv_t'{vec_t'{32'h900, 4'b0000, 32'h0,         1'b0, 3'b100, 3'b100, 1'b1, 32'h2000,      2'd2, 32'h0},
                        exp_t'{1'b1, 1'b0, 1'b1, 4'd11, 32'h0,    32'h2000},                           3'd0, 3'd0};
        tbl[9]  = tv_t'{vec_t'{32'hA00, 4'b0000, 32'h0,         1'b0, 3'b100, 3'b100, 1'b1, 32'hFFFF_FFF0, 2'd1, 32'h0},
                        exp_t'{1'b1, 1'b0, 1'b1, 4'd11, 32'h0,    VEC ? 32'h1C : 32'hFFFF_FFF0},       3'd0, 3'd0};
        tbl[10] = tv_t'{vec_t'{32'hB00, 4'b0010, 32'h99,        1'b1, 3'b000, 3'b000, 1'b0, 32'h800,       2'd0, 32'h3000},
                        exp_t'{1'b1, 1'b0, 1'b0, 4'd2,  32'h99,   32'h800},                            3'd0, 3'd0};
        tbl[11] = tv_t'{vec_t'{32'hC00, 4'b0000, 32'h0,         1'b0, 3'b100, 3'b011, 1'b1, 32'h800,       2'd0, 32'h0},
                        exp_t'{1'b0, 1'b0, 1'b0, 4'd0,  32'h0,    32'h0},                              3'd0, 3'd0};
        tbl[12] = tv_t'{vec_t'{32'hD00, 4'b0000, 32'h0,         1'b0, 3'b101, 3'b001, 1'b1, 32'h800,       2'd0, 32'h0},
                        exp_t'{1'b1, 1'b0, 1'b1, 4'd3,  32'h0,    32'h800},                            3'd0, 3'd0};
        tbl[13] = tv_t'{vec_t'{32'hE00, 4'b0001, 32'hABC,       1'b0, 3'b001, 3'b001, 1'b0, 32'h400,       2'd1, 32'h0},
                        exp_t'{1'b1, 1'b0, 1'b0, 4'd0,  32'hABC,  32'h400},                            3'd0, 3'd0};

        drive_idle();
        mie_msie = 1'b0; mie_mtie = 1'b0; mie_meie = 1'b0; mstatus_mie = 1'b0;
        mtvec_base = '0; mtvec_mode = '0; mepc = '0;
        flush_ack = 1'b0; redirect_rdy = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rstl = 1'b1;
        @(negedge clk);

        // Directed table, run back to back.
        for (int i = 0; i < 14; i++) begin
            run_txn(tbl[i].v, tbl[i].e, int'(tbl[i].ack_dly), int'(tbl[i].rdy_dly), $sformatf("tbl%0d", i));
        end

        // Asynchronous reset while flushing, then a normal ecall.
        v = tbl[0].v;
        v.pc = 32'h300;
        drive_boundary(v);
        @(negedge clk);
        check("rst_pre flush", flush, 1);
        #2 rstl = 1'b0;
        #1 check_all_zero("rst_flush");
        drive_idle();
        @(negedge clk);
        rstl = 1'b1;
        @(negedge clk);
        check("rst_post idle", busy, 0);
        v.pc = 32'h340;
        run_txn(v, model(v), 0, 0, "post_rst");

        // Randomized boundaries against the model.
        for (int i = 0; i < 40; i++) begin
            v = rand_vec();
            e = model(v);
            run_txn(v, e, $urandom_range(0, 3), $urandom_range(0, 3), $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
